// File: rtl/lut_eval_pkg.sv
// Shared types and helpers for the LUT evaluation engine.
// Holds the FSM state type and the MSB-first truth-table row lookup.
package lut_eval_pkg;

   localparam int MAX_N_IN = 6;
   localparam int MAX_TT_W = 64;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DONE  = 2'd2
   } state_t;

   function automatic int tt_width(input int n);
      return 1 << n;
   endfunction

   // Row 0 (all-zero inputs) selects the table MSB, so the table reads like a truth-table column top-down.
   function automatic logic tt_lookup(input logic [MAX_TT_W-1:0] tbl,
                                      input logic [MAX_N_IN-1:0] row,
                                      input int n);
      logic [MAX_N_IN-1:0] idx;
      idx = 6'((1 << n) - 1) - row;
      return tbl[idx];
   endfunction

endpackage

// File: rtl/lut_row_select.sv
// Combinational truth-table mux: picks the function value for one input row.
// Shared by the evaluation path and the sweep path of the engine.
module lut_row_select
   import lut_eval_pkg::*;
#(
   parameter int N_IN = 3
)(
   input  logic [(1<<N_IN)-1:0] i_table,
   input  logic [N_IN-1:0]      i_row,
   output logic                 o_bit
);

   localparam int TT_W = tt_width(N_IN);

   logic [MAX_TT_W-1:0] w_tbl;
   logic [MAX_N_IN-1:0] w_row;

   always_comb begin
      w_tbl              = '0;
      w_tbl[TT_W-1:0]    = i_table;
      w_row              = '0;
      w_row[N_IN-1:0]    = i_row;
      o_bit              = tt_lookup(w_tbl, w_row, N_IN);
   end

endmodule

// File: rtl/lut_eval_engine.sv
// Runtime-loadable N-input truth-table evaluator with a registered valid/ready
// evaluation channel and an exhaustive self-checking sweep mode.
module lut_eval_engine
   import lut_eval_pkg::*;
#(
   parameter int                  N_IN    = 3,
   parameter logic [(1<<N_IN)-1:0] TT_INIT = 8'hAB
)(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   cfg_load,
   input  logic [(1<<N_IN)-1:0]   cfg_tt,
   output logic                   cfg_err,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [N_IN-1:0]        in_vec,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   out_bit,
   output logic [N_IN-1:0]        out_row,
   input  logic                   sweep_start,
   input  logic [(1<<N_IN)-1:0]   sweep_expect,
   output logic                   busy,
   output logic                   sweep_done,
   output logic [(1<<N_IN)-1:0]   sweep_word,
   output logic                   sweep_fail
);

   localparam int TT_W = tt_width(N_IN);
   localparam logic [N_IN:0] LAST_ROW = {1'b0, {N_IN{1'b1}}};

   state_t            r_state;
   logic [TT_W-1:0]   r_table;
   logic [TT_W-1:0]   r_expect;
   logic [TT_W-1:0]   r_sweep_word;
   logic              r_sweep_fail;
   logic              r_cfg_err;
   logic              r_out_valid;
   logic              r_out_bit;
   logic [N_IN-1:0]   r_out_row;
   logic [N_IN:0]     r_ctr;

   logic              w_idle;
   logic              w_in_ready;
   logic              w_xfer;
   logic              w_cfg_ok;
   logic              w_sweep_ok;
   logic              w_cfg_rej;
   logic              w_last;
   logic              w_bit;
   logic [N_IN-1:0]   w_sel_row;
   logic [N_IN-1:0]   w_word_idx;
   logic [TT_W-1:0]   w_word_next;

   assign w_idle     = (r_state == IDLE);
   assign w_in_ready = w_idle && (!r_out_valid || out_ready);
   assign w_xfer     = in_valid && w_in_ready;
   assign w_cfg_ok   = cfg_load && w_idle;
   // A sweep must not start while a result is pending, and a same-cycle load takes priority.
   assign w_sweep_ok = sweep_start && w_idle && !cfg_load && !r_out_valid;
   assign w_cfg_rej  = (cfg_load && !w_idle) || (sweep_start && !w_sweep_ok);
   assign w_last     = (r_ctr == LAST_ROW);
   assign w_sel_row  = (r_state == SWEEP) ? r_ctr[N_IN-1:0] : in_vec;
   assign w_word_idx = ~r_ctr[N_IN-1:0];

   lut_row_select #(.N_IN(N_IN)) u_row_select (
      .i_table (r_table),
      .i_row   (w_sel_row),
      .o_bit   (w_bit)
   );

   always_comb begin
      w_word_next             = r_sweep_word;
      w_word_next[w_word_idx] = w_bit;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_table   <= TT_INIT;
         r_cfg_err <= 1'b0;
      end else begin
         r_cfg_err <= w_cfg_rej;
         if (w_cfg_ok) begin
            r_table <= cfg_tt;
         end
      end
   end

   // Output slice holds its result until the consumer takes it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_bit   <= 1'b0;
         r_out_row   <= '0;
      end else if (w_xfer) begin
         r_out_valid <= 1'b1;
         r_out_bit   <= w_bit;
         r_out_row   <= in_vec;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_expect     <= '0;
         r_sweep_word <= '0;
         r_sweep_fail <= 1'b0;
         r_ctr        <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_sweep_ok) begin
                  r_expect     <= sweep_expect;
                  r_sweep_word <= '0;
                  r_sweep_fail <= 1'b0;
                  r_ctr        <= '0;
                  r_state      <= SWEEP;
               end
            end
            SWEEP: begin
               r_sweep_word <= w_word_next;
               r_ctr        <= r_ctr + 1'b1;
               // Verdict uses the word including the final row so it is valid alongside sweep_done.
               if (w_last) begin
                  r_sweep_fail <= (w_word_next != r_expect);
                  r_state      <= DONE;
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign cfg_err    = r_cfg_err;
   assign in_ready   = w_in_ready;
   assign out_valid  = r_out_valid;
   assign out_bit    = r_out_bit;
   assign out_row    = r_out_row;
   assign busy       = (r_state == SWEEP);
   assign sweep_done = (r_state == DONE);
   assign sweep_word = r_sweep_word;
   assign sweep_fail = r_sweep_fail;

endmodule

// File: tb/tb_lut_eval_engine.sv
// Directed bench for lut_eval_engine: default 3-input build plus a 6-input
// build used for the long sweep and the mid-sweep reset.
module tb_lut_eval_engine;

   localparam logic [63:0] INIT6 = 64'hDEADBEEF01234567;

   logic        clk;
   logic        rst_n;
   logic        rst6_n;

   logic        cfg_load, cfg_err, in_valid, in_ready, out_valid, out_ready, out_bit;
   logic [7:0]  cfg_tt, sweep_expect, sweep_word;
   logic [2:0]  in_vec, out_row;
   logic        sweep_start, busy, sweep_done, sweep_fail;

   logic        cfg_load6, cfg_err6, in_valid6, in_ready6, out_valid6, out_ready6, out_bit6;
   logic [63:0] cfg_tt6, sweep_expect6, sweep_word6;
   logic [5:0]  in_vec6, out_row6;
   logic        sweep_start6, busy6, sweep_done6, sweep_fail6;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [2:0] vec;
      logic       expBit;
   } vec_t;

   vec_t vecs [8];

   lut_eval_engine dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_load(cfg_load), .cfg_tt(cfg_tt), .cfg_err(cfg_err),
      .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
      .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit), .out_row(out_row),
      .sweep_start(sweep_start), .sweep_expect(sweep_expect), .busy(busy),
      .sweep_done(sweep_done), .sweep_word(sweep_word), .sweep_fail(sweep_fail)
   );

   lut_eval_engine #(.N_IN(6), .TT_INIT(INIT6)) dut6 (
      .clk(clk), .rst_n(rst6_n),
      .cfg_load(cfg_load6), .cfg_tt(cfg_tt6), .cfg_err(cfg_err6),
      .in_valid(in_valid6), .in_ready(in_ready6), .in_vec(in_vec6),
      .out_valid(out_valid6), .out_ready(out_ready6), .out_bit(out_bit6), .out_row(out_row6),
      .sweep_start(sweep_start6), .sweep_expect(sweep_expect6), .busy(busy6),
      .sweep_done(sweep_done6), .sweep_word(sweep_word6), .sweep_fail(sweep_fail6)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic [2:0] vec, input logic valid, input logic ready);
      in_vec    = vec;
      in_valid  = valid;
      out_ready = ready;
   endtask

   // Runs one sweep on the 3-input engine; optionally pokes cfg_load/sweep_start mid-sweep.
   task automatic runSweep(input logic [7:0] exp, input logic inject,
                           output int nBusy, output logic gotDone);
      sweep_start  = 1'b1;
      sweep_expect = exp;
      step();
      sweep_start = 1'b0;
      nBusy   = busy ? 1 : 0;
      gotDone = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (inject && k == 2) begin
            sweep_start  = 1'b1;
            sweep_expect = 8'h00;
            cfg_load     = 1'b1;
            cfg_tt       = 8'h00;
         end
         step();
         if (inject && k == 2) begin
            sweep_start = 1'b0;
            cfg_load    = 1'b0;
            checkOutput("cfg_err_during_sweep", cfg_err, 1'b1);
         end
         if (inject && k == 3) checkOutput("cfg_err_pulse_end", cfg_err, 1'b0);
         if (sweep_done) begin
            gotDone = 1'b1;
            break;
         end
         if (busy) nBusy++;
      end
   endtask

   int   nBusy;
   logic gotDone;

   initial begin
      vecs[0] = '{3'd0, 1'b1}; vecs[1] = '{3'd1, 1'b0};
      vecs[2] = '{3'd2, 1'b1}; vecs[3] = '{3'd3, 1'b0};
      vecs[4] = '{3'd4, 1'b1}; vecs[5] = '{3'd5, 1'b0};
      vecs[6] = '{3'd6, 1'b1}; vecs[7] = '{3'd7, 1'b1};

      rst_n = 1'b1; rst6_n = 1'b1;
      cfg_load = 0; cfg_tt = '0; in_valid = 0; in_vec = '0; out_ready = 1;
      sweep_start = 0; sweep_expect = '0;
      cfg_load6 = 0; cfg_tt6 = '0; in_valid6 = 0; in_vec6 = '0; out_ready6 = 1;
      sweep_start6 = 0; sweep_expect6 = '0;
      #2;
      rst_n = 1'b0; rst6_n = 1'b0;
      repeat (2) step();

      checkOutput("rst_out_valid", out_valid, 1'b0);
      checkOutput("rst_out_bit", out_bit, 1'b0);
      checkOutput("rst_out_row", out_row, 3'd0);
      checkOutput("rst_in_ready", in_ready, 1'b1);
      checkOutput("rst_busy", busy, 1'b0);
      checkOutput("rst_sweep_done", sweep_done, 1'b0);
      checkOutput("rst_sweep_word", sweep_word, 8'h00);
      checkOutput("rst_sweep_fail", sweep_fail, 1'b0);
      checkOutput("rst_cfg_err", cfg_err, 1'b0);
      rst_n = 1'b1; rst6_n = 1'b1;
      step();

      applyStimulus(3'b001, 1'b1, 1'b1);
      step();
      checkOutput("first_valid", out_valid, 1'b1);
      checkOutput("first_bit", out_bit, 1'b0);
      checkOutput("first_row", out_row, 3'd1);
      applyStimulus(3'b000, 1'b0, 1'b1);
      step();
      checkOutput("first_drain", out_valid, 1'b0);

      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i].vec, 1'b1, 1'b1);
         step();
         checkOutput($sformatf("stream_valid_%0d", i), out_valid, 1'b1);
         checkOutput($sformatf("stream_bit_%0d", i), out_bit, vecs[i].expBit);
         checkOutput($sformatf("stream_row_%0d", i), out_row, vecs[i].vec);
      end
      applyStimulus(3'b000, 1'b0, 1'b1);
      step();
      checkOutput("stream_drain", out_valid, 1'b0);

      applyStimulus(3'd2, 1'b1, 1'b0);
      step();
      checkOutput("bp_valid", out_valid, 1'b1);
      applyStimulus(3'd3, 1'b1, 1'b0);
      #1;
      checkOutput("bp_in_ready_low", in_ready, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step();
         checkOutput($sformatf("bp_hold_valid_%0d", i), out_valid, 1'b1);
         checkOutput($sformatf("bp_hold_bit_%0d", i), out_bit, 1'b1);
         checkOutput($sformatf("bp_hold_row_%0d", i), out_row, 3'd2);
      end
      out_ready = 1'b1;
      #1;
      checkOutput("bp_in_ready_release", in_ready, 1'b1);
      step();
      checkOutput("bp_next_valid", out_valid, 1'b1);
      checkOutput("bp_next_bit", out_bit, 1'b0);
      checkOutput("bp_next_row", out_row, 3'd3);
      applyStimulus(3'd0, 1'b0, 1'b1);
      step();

      cfg_load = 1'b1; cfg_tt = 8'h96;
      applyStimulus(3'd0, 1'b1, 1'b1);
      step();
      cfg_load = 1'b0;
      checkOutput("load_same_cycle_row0", out_bit, 1'b1);
      applyStimulus(3'd0, 1'b1, 1'b1);
      step();
      checkOutput("new96_row0", out_bit, 1'b1);
      applyStimulus(3'd1, 1'b1, 1'b1);
      step();
      checkOutput("new96_row1", out_bit, 1'b0);
      cfg_load = 1'b1; cfg_tt = 8'hAB;
      applyStimulus(3'd3, 1'b1, 1'b1);
      step();
      cfg_load = 1'b0;
      checkOutput("load_same_cycle_old_row3", out_bit, 1'b1);
      applyStimulus(3'd3, 1'b1, 1'b1);
      step();
      checkOutput("newAB_row3", out_bit, 1'b0);

      applyStimulus(3'd5, 1'b1, 1'b0);
      step();
      applyStimulus(3'd5, 1'b0, 1'b0);
      sweep_start = 1'b1; sweep_expect = 8'hAB;
      step();
      sweep_start = 1'b0;
      checkOutput("sweep_pending_cfg_err", cfg_err, 1'b1);
      checkOutput("sweep_pending_busy", busy, 1'b0);
      out_ready = 1'b1;
      step();
      checkOutput("sweep_pending_drained", out_valid, 1'b0);

      runSweep(8'hAB, 1'b0, nBusy, gotDone);
      checkOutput("sweepA_done", gotDone, 1'b1);
      checkOutput("sweepA_busy_cycles", nBusy, 8);
      checkOutput("sweepA_word", sweep_word, 8'hAB);
      checkOutput("sweepA_fail", sweep_fail, 1'b0);
      checkOutput("sweepA_busy_at_done", busy, 1'b0);
      step();
      checkOutput("sweepA_done_pulse", sweep_done, 1'b0);
      checkOutput("sweepA_idle_ready", in_ready, 1'b1);

      runSweep(8'hAA, 1'b1, nBusy, gotDone);
      checkOutput("sweepB_done", gotDone, 1'b1);
      checkOutput("sweepB_busy_cycles", nBusy, 8);
      checkOutput("sweepB_word", sweep_word, 8'hAB);
      checkOutput("sweepB_fail", sweep_fail, 1'b1);
      step();
      checkOutput("sweepB_fail_held", sweep_fail, 1'b1);
      applyStimulus(3'd6, 1'b1, 1'b1);
      step();
      checkOutput("table_kept_after_sweep", out_bit, 1'b1);
      applyStimulus(3'd0, 1'b0, 1'b1);
      step();

      sweep_start6 = 1'b1; sweep_expect6 = INIT6;
      step();
      sweep_start6 = 1'b0;
      repeat (30) step();
      checkOutput("n6_partial_word", sweep_word6, 64'hDEADBEEC00000000);
      checkOutput("n6_busy_mid", busy6, 1'b1);
      rst6_n = 1'b0;
      #1;
      checkOutput("n6_rst_busy", busy6, 1'b0);
      checkOutput("n6_rst_word", sweep_word6, 64'h0);
      checkOutput("n6_rst_done", sweep_done6, 1'b0);
      checkOutput("n6_rst_fail", sweep_fail6, 1'b0);
      checkOutput("n6_rst_out_valid", out_valid6, 1'b0);
      checkOutput("n6_rst_in_ready", in_ready6, 1'b1);
      checkOutput("n6_rst_cfg_err", cfg_err6, 1'b0);
      step();
      rst6_n = 1'b1;
      in_valid6 = 1'b1; in_vec6 = 6'd0;
      step();
      checkOutput("n6_row0", out_bit6, 1'b1);
      in_vec6 = 6'd2;
      step();
      checkOutput("n6_row2", out_bit6, 1'b0);
      checkOutput("n6_row2_id", out_row6, 6'd2);
      in_valid6 = 1'b0;
      step();

      sweep_start6 = 1'b1; sweep_expect6 = INIT6;
      step();
      sweep_start6 = 1'b0;
      nBusy = busy6 ? 1 : 0;
      gotDone = 1'b0;
      for (int k = 0; k < 100; k++) begin
         step();
         if (sweep_done6) begin
            gotDone = 1'b1;
            break;
         end
         if (busy6) nBusy++;
      end
      checkOutput("n6_sweep_done", gotDone, 1'b1);
      checkOutput("n6_sweep_busy_cycles", nBusy, 64);
      checkOutput("n6_sweep_word", sweep_word6, INIT6);
      checkOutput("n6_sweep_fail", sweep_fail6, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
